// File: rtl/rp_pio_pkg.sv
// Shared types and helpers for the Root Port PIO error status logger.
package rp_pio_pkg;

  // Request address space of the failed PIO request
  typedef enum logic [1:0] {
    SpaceCfg  = 2'd0,
    SpaceIo   = 2'd1,
    SpaceMem  = 2'd2,
    SpaceRsvd = 2'd3
  } pio_space_e;

  // Completion error cause
  typedef enum logic [1:0] {
    CauseUr   = 2'd0,
    CauseCa   = 2'd1,
    CauseCto  = 2'd2,
    CauseRsvd = 2'd3
  } pio_cause_e;

  // Implemented status/mask bits: Cfg 0-2, I/O 8-10, Mem 16-18
  localparam logic [31:0] StatusValidMask = 32'h0007_0707;

  // First-error capture FSM
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StLocked  = 2'd2
  } pio_state_e;

  // Bit index = 8*space + cause
  function automatic logic [4:0] pio_bit_idx(input logic [1:0] space, input logic [1:0] cause);
    return {space, 1'b0, cause};
  endfunction

endpackage

// File: rtl/rp_pio_hdr_log.sv
// Header capture buffer: loads the request header of the first logged error.
module rp_pio_hdr_log #(
  parameter int unsigned HDR_DW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic [HDR_DW*32-1:0]  hdr_new,
  output logic [HDR_DW*32-1:0]  hdr_log
);

  logic [HDR_DW*32-1:0] hdr_q;

  // Sticky header register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q <= '0;
    end else if (capture) begin
      hdr_q <= hdr_new;
    end
  end

  assign hdr_log = hdr_q;

endmodule

// File: rtl/rp_pio_status_logger.sv
// Root Port PIO error status and logging stage.
// Filters completion-error events with the mask word, sets sticky RW1C status
// bits, captures a first-error pointer and (optionally) the request header,
// and pulses a DPC trigger. Header buffer enabled by defining RP_PIO_HDR_LOG_EN.
module rp_pio_status_logger
  import rp_pio_pkg::*;
#(
  parameter int unsigned HDR_DW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  err_valid,
  output logic                  err_ready,
  input  logic [1:0]            err_space,
  input  logic [1:0]            err_cause,
  input  logic [HDR_DW*32-1:0]  err_hdr,
  input  logic [31:0]           mask,
  input  logic                  status_we,
  input  logic [31:0]           status_wdata,
  output logic [31:0]           status_rdata,
  output logic [4:0]            first_err_ptr,
  output logic                  first_err_vld,
  output logic [HDR_DW*32-1:0]  hdr_log,
  output logic                  dpc_trig
);

  pio_state_e  state_q, state_d;
  logic [31:0] status_q, status_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        trig_q;

  logic [4:0]  evt_idx;
  logic        evt_rsvd;
  logic        evt_hit;
  logic        hdr_capture;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // Only the single CAPTURE cycle back-pressures the event source
  assign err_ready = (state_q != StCapture);

  // Decode the offered event and decide whether it is an accepted, unmasked error
  always_comb begin
    evt_idx  = pio_bit_idx(err_space, err_cause);
    evt_rsvd = (pio_space_e'(err_space) == SpaceRsvd) ||
               (pio_cause_e'(err_cause) == CauseRsvd);
    evt_hit  = err_valid && err_ready && !evt_rsvd && !mask[evt_idx];
  end

  // RW1C status update; a same-cycle set beats a software clear
  always_comb begin
    clr_vec = status_we ? status_wdata : 32'h0;
    set_vec = 32'h0;
    if (evt_hit) begin
      set_vec[evt_idx] = 1'b1;
    end
    status_d = ((status_q & ~clr_vec) | set_vec) & StatusValidMask;
  end

  // First-error FSM: arm in IDLE, one CAPTURE cycle, hold until pointed bit clears
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hdr_capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (evt_hit) begin
          state_d     = StCapture;
          ptr_d       = evt_idx;
          hdr_capture = 1'b1;
        end
      end
      StCapture: begin
        state_d = StLocked;
      end
      StLocked: begin
        // Registered status is used so a clear during CAPTURE releases one cycle later
        if (!status_q[ptr_q]) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sticky state, cleared only by the sticky-domain reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      status_q <= 32'h0;
      ptr_q    <= 5'd0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      ptr_q    <= ptr_d;
      trig_q   <= evt_hit;
    end
  end

  assign status_rdata  = status_q;
  assign first_err_ptr = ptr_q;
  assign first_err_vld = (state_q != StIdle);
  assign dpc_trig      = trig_q;

`ifdef RP_PIO_HDR_LOG_EN
  rp_pio_hdr_log #(
    .HDR_DW (HDR_DW)
  ) u_hdr_log (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (hdr_capture),
    .hdr_new (err_hdr),
    .hdr_log (hdr_log)
  );
`else
  // No header flops; header input and capture strobe are intentionally dropped
  logic unused_hdr;
  assign unused_hdr = ^{err_hdr, hdr_capture};
  assign hdr_log    = '0;
`endif

endmodule

// File: tb/tb_rp_pio_status_logger.sv
// Directed self-checking bench for rp_pio_status_logger.
module tb_rp_pio_status_logger;

  localparam int unsigned HdrW = 128;

  logic            clk;
  logic            rst_n;
  logic            err_valid;
  logic            err_ready;
  logic [1:0]      err_space;
  logic [1:0]      err_cause;
  logic [HdrW-1:0] err_hdr;
  logic [31:0]     mask;
  logic            status_we;
  logic [31:0]     status_wdata;
  logic [31:0]     status_rdata;
  logic [4:0]      first_err_ptr;
  logic            first_err_vld;
  logic [HdrW-1:0] hdr_log;
  logic            dpc_trig;

  int n_cmp;
  int n_err;

  logic [HdrW-1:0] hdr_a;
  logic [HdrW-1:0] hdr_b;
  logic [HdrW-1:0] hdr_c;
  logic [HdrW-1:0] hdr_d;

  rp_pio_status_logger #(
    .HDR_DW (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .err_valid     (err_valid),
    .err_ready     (err_ready),
    .err_space     (err_space),
    .err_cause     (err_cause),
    .err_hdr       (err_hdr),
    .mask          (mask),
    .status_we     (status_we),
    .status_wdata  (status_wdata),
    .status_rdata  (status_rdata),
    .first_err_ptr (first_err_ptr),
    .first_err_vld (first_err_vld),
    .hdr_log       (hdr_log),
    .dpc_trig      (dpc_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected header log value for a captured header
  function automatic logic [HdrW-1:0] exp_hdr(input logic [HdrW-1:0] h);
`ifdef RP_PIO_HDR_LOG_EN
    return h;
`else
    return {HdrW{1'b0}} & h;
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    err_valid    = 1'b0;
    err_space    = 2'd0;
    err_cause    = 2'd0;
    err_hdr      = '0;
    mask         = 32'h0;
    status_we    = 1'b0;
    status_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
  endtask

  // Offer one event for one cycle; returns at N+1 (+1ns)
  task automatic drive_evt(input logic [1:0] s, input logic [1:0] c, input logic [HdrW-1:0] h);
    err_valid = 1'b1;
    err_space = s;
    err_cause = c;
    err_hdr   = h;
    cycle();
    err_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (status_rdata !== 32'h0) begin n_err++; $display("FAIL reset_status got %h want %h", status_rdata, 32'h0); end
    n_cmp++; if (first_err_ptr !== 5'd0) begin n_err++; $display("FAIL reset_ptr got %0d want 0", first_err_ptr); end
    n_cmp++; if (first_err_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", first_err_vld); end
    n_cmp++; if (hdr_log !== '0) begin n_err++; $display("FAIL reset_hdr got %h want 0", hdr_log); end
    n_cmp++; if (dpc_trig !== 1'b0) begin n_err++; $display("FAIL reset_trig got %b want 0", dpc_trig); end
    n_cmp++; if (err_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", err_ready); end
  endtask

  task automatic test_mem_cto();
    do_reset();
    drive_evt(2'd2, 2'd2, hdr_a);
    n_cmp++; if (status_rdata !== 32'h0004_0000) begin n_err++; $display("FAIL mem_cto_status got %h want %h", status_rdata, 32'h0004_0000); end
    n_cmp++; if (first_err_ptr !== 5'd18) begin n_err++; $display("FAIL mem_cto_ptr got %0d want 18", first_err_ptr); end
    n_cmp++; if (dpc_trig !== 1'b1) begin n_err++; $display("FAIL mem_cto_trig got %b want 1", dpc_trig); end
    n_cmp++; if (first_err_vld !== 1'b1) begin n_err++; $display("FAIL mem_cto_vld got %b want 1", first_err_vld); end
    n_cmp++; if (err_ready !== 1'b0) begin n_err++; $display("FAIL mem_cto_ready_capture got %b want 0", err_ready); end
    n_cmp++; if (hdr_log !== exp_hdr(hdr_a)) begin n_err++; $display("FAIL mem_cto_hdr got %h want %h", hdr_log, exp_hdr(hdr_a)); end
    cycle();
    n_cmp++; if (dpc_trig !== 1'b0) begin n_err++; $display("FAIL mem_cto_trig_once got %b want 0", dpc_trig); end
    n_cmp++; if (err_ready !== 1'b1) begin n_err++; $display("FAIL mem_cto_ready_locked got %b want 1", err_ready); end
  endtask

  task automatic test_all_masked();
    int pulses;
    do_reset();
    mask   = 32'h0007_0707;
    pulses = 0;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 3; c++) begin
        drive_evt(2'(s), 2'(c), hdr_b);
        if (dpc_trig === 1'b1) pulses++;
      end
    end
    cycle();
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL masked_trig_pulses got %0d want 0", pulses); end
    n_cmp++; if (status_rdata !== 32'h0) begin n_err++; $display("FAIL masked_status got %h want 0", status_rdata); end
    n_cmp++; if (first_err_vld !== 1'b0) begin n_err++; $display("FAIL masked_vld got %b want 0", first_err_vld); end
  endtask

  task automatic test_lock_release();
    do_reset();
    drive_evt(2'd0, 2'd0, hdr_a);   // Cfg UR -> bit 0
    cycle();
    drive_evt(2'd1, 2'd1, hdr_b);   // I/O CA -> bit 9
    n_cmp++; if (status_rdata !== 32'h0000_0201) begin n_err++; $display("FAIL lock_status got %h want %h", status_rdata, 32'h0000_0201); end
    n_cmp++; if (first_err_ptr !== 5'd0) begin n_err++; $display("FAIL lock_ptr got %0d want 0", first_err_ptr); end
    n_cmp++; if (hdr_log !== exp_hdr(hdr_a)) begin n_err++; $display("FAIL lock_hdr got %h want %h", hdr_log, exp_hdr(hdr_a)); end
    n_cmp++; if (dpc_trig !== 1'b1) begin n_err++; $display("FAIL lock_second_trig got %b want 1", dpc_trig); end
    status_we = 1'b1; status_wdata = 32'h0000_0200;
    cycle();
    status_we = 1'b0;
    cycle(); cycle();
    n_cmp++; if (status_rdata !== 32'h0000_0001) begin n_err++; $display("FAIL lock_clr_other_status got %h want %h", status_rdata, 32'h0000_0001); end
    n_cmp++; if (first_err_vld !== 1'b1) begin n_err++; $display("FAIL lock_clr_other_vld got %b want 1", first_err_vld); end
    status_we = 1'b1; status_wdata = 32'h0000_0001;
    cycle();
    status_we = 1'b0;
    cycle();
    n_cmp++; if (first_err_vld !== 1'b0) begin n_err++; $display("FAIL lock_release_vld got %b want 0", first_err_vld); end
    drive_evt(2'd1, 2'd0, hdr_c);   // I/O UR re-arms -> bit 8
    n_cmp++; if (first_err_ptr !== 5'd8) begin n_err++; $display("FAIL rearm_ptr got %0d want 8", first_err_ptr); end
    n_cmp++; if (hdr_log !== exp_hdr(hdr_c)) begin n_err++; $display("FAIL rearm_hdr got %h want %h", hdr_log, exp_hdr(hdr_c)); end
  endtask

  task automatic test_set_clear_same();
    do_reset();
    drive_evt(2'd1, 2'd0, hdr_a);   // lock on bit 8
    cycle();
    status_we = 1'b1; status_wdata = 32'h0000_0100;
    drive_evt(2'd1, 2'd0, hdr_b);
    status_we = 1'b0;
    n_cmp++; if (status_rdata !== 32'h0000_0100) begin n_err++; $display("FAIL setclr_status got %h want %h", status_rdata, 32'h0000_0100); end
    cycle(); cycle();
    n_cmp++; if (first_err_vld !== 1'b1) begin n_err++; $display("FAIL setclr_lock_held got %b want 1", first_err_vld); end
  endtask

  task automatic test_capture_clear();
    do_reset();
    drive_evt(2'd0, 2'd1, hdr_a);   // Cfg CA -> bit 1, now in CAPTURE
    status_we = 1'b1; status_wdata = 32'h0000_0002;
    cycle();
    status_we = 1'b0;
    n_cmp++; if (status_rdata !== 32'h0) begin n_err++; $display("FAIL capclr_status got %h want 0", status_rdata); end
    n_cmp++; if (first_err_vld !== 1'b1) begin n_err++; $display("FAIL capclr_locked_vld got %b want 1", first_err_vld); end
    cycle();
    n_cmp++; if (first_err_vld !== 1'b0) begin n_err++; $display("FAIL capclr_release_vld got %b want 0", first_err_vld); end
  endtask

  task automatic test_reset_in_capture();
    do_reset();
    drive_evt(2'd2, 2'd0, hdr_c);   // Mem UR -> bit 16, now in CAPTURE
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (status_rdata !== 32'h0) begin n_err++; $display("FAIL rstcap_status got %h want 0", status_rdata); end
    n_cmp++; if (first_err_ptr !== 5'd0) begin n_err++; $display("FAIL rstcap_ptr got %0d want 0", first_err_ptr); end
    n_cmp++; if (first_err_vld !== 1'b0) begin n_err++; $display("FAIL rstcap_vld got %b want 0", first_err_vld); end
    n_cmp++; if (hdr_log !== '0) begin n_err++; $display("FAIL rstcap_hdr got %h want 0", hdr_log); end
    n_cmp++; if (dpc_trig !== 1'b0) begin n_err++; $display("FAIL rstcap_trig got %b want 0", dpc_trig); end
    n_cmp++; if (err_ready !== 1'b1) begin n_err++; $display("FAIL rstcap_ready got %b want 1", err_ready); end
    #1 rst_n = 1'b1;
    cycle();
    drive_evt(2'd0, 2'd2, hdr_d);   // Cfg CTO -> bit 2
    n_cmp++; if (status_rdata !== 32'h0000_0004) begin n_err++; $display("FAIL rstcap_next_status got %h want %h", status_rdata, 32'h0000_0004); end
    n_cmp++; if (first_err_ptr !== 5'd2) begin n_err++; $display("FAIL rstcap_next_ptr got %0d want 2", first_err_ptr); end
    n_cmp++; if (hdr_log !== exp_hdr(hdr_d)) begin n_err++; $display("FAIL rstcap_next_hdr got %h want %h", hdr_log, exp_hdr(hdr_d)); end
  endtask

  task automatic test_reserved();
    do_reset();
    err_valid = 1'b1; err_space = 2'd3; err_cause = 2'd0; err_hdr = hdr_a;
    #1;
    n_cmp++; if (err_ready !== 1'b1) begin n_err++; $display("FAIL rsvd_space_ready got %b want 1", err_ready); end
    cycle();
    err_valid = 1'b0;
    n_cmp++; if (status_rdata !== 32'h0) begin n_err++; $display("FAIL rsvd_space_status got %h want 0", status_rdata); end
    n_cmp++; if (dpc_trig !== 1'b0) begin n_err++; $display("FAIL rsvd_space_trig got %b want 0", dpc_trig); end
    drive_evt(2'd1, 2'd3, hdr_b);
    n_cmp++; if (status_rdata !== 32'h0) begin n_err++; $display("FAIL rsvd_cause_status got %h want 0", status_rdata); end
    n_cmp++; if (first_err_vld !== 1'b0) begin n_err++; $display("FAIL rsvd_cause_vld got %b want 0", first_err_vld); end
    n_cmp++; if (err_ready !== 1'b1) begin n_err++; $display("FAIL rsvd_cause_ready got %b want 1", err_ready); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    hdr_a = 128'hA0A0_0001_1111_2222_3333_4444_5555_6666;
    hdr_b = 128'hB0B0_0002_7777_8888_9999_AAAA_BBBB_CCCC;
    hdr_c = 128'hC0C0_0003_DEAD_BEEF_0123_4567_89AB_CDEF;
    hdr_d = 128'hD0D0_0004_FEDC_BA98_7654_3210_0F0F_F0F0;
    test_reset();
    test_mem_cto();
    test_all_masked();
    test_lock_release();
    test_set_clear_same();
    test_capture_clear();
    test_reset_in_capture();
    test_reserved();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
